// File: rtl/matrix_mult_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_pkg                                                    |
// | Purpose  : Shared definitions for the 2x2 matrix multiply sequencer:     |
// |            register map addresses, CTRL/STATUS bit positions, FSM state  |
// |            encoding and default operand/result widths.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package matrix_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ACC_W_DEFAULT  = 32;

  // Word addresses on the Avalon-MM slave
  localparam logic [3:0] ADDR_A11    = 4'd0;
  localparam logic [3:0] ADDR_A12    = 4'd1;
  localparam logic [3:0] ADDR_A21    = 4'd2;
  localparam logic [3:0] ADDR_A22    = 4'd3;
  localparam logic [3:0] ADDR_B11    = 4'd4;
  localparam logic [3:0] ADDR_B12    = 4'd5;
  localparam logic [3:0] ADDR_B21    = 4'd6;
  localparam logic [3:0] ADDR_B22    = 4'd7;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;
  localparam logic [3:0] ADDR_C11    = 4'd10;
  localparam logic [3:0] ADDR_C12    = 4'd11;
  localparam logic [3:0] ADDR_C21    = 4'd12;
  localparam logic [3:0] ADDR_C22    = 4'd13;

  // CTRL bits (write-only)
  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR_ERR = 1;
  localparam int CTRL_CLR_OVF = 2;

  // STATUS bits (read-only)
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_OVF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/matrix_mult_sequencer_mac_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mac_unit                                                      |
// | Purpose  : Registered signed multiplier feeding a load/add accumulator   |
// |            with a sticky signed-overflow flag.                           |
// | Ports    : clk, rst        - clock, async active-high reset              |
// |            issue, load     - product request; load=1 starts a new sum    |
// |            op_a, op_b      - signed operands                             |
// |            ovf_clr         - clear the sticky overflow flag              |
// |            result          - value the accumulator takes this cycle      |
// |            result_valid    - result is a finished two-term sum           |
// |            ovf             - sticky overflow flag                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mac_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  input  logic                     ovf_clr,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  output logic                     ovf
);

  logic signed [2*DATA_W-1:0] mul_full;
  logic signed [ACC_W-1:0]    prod_d, prod_q;
  logic signed [ACC_W-1:0]    acc_d, acc_q;
  logic signed [ACC_W-1:0]    sum;
  logic                       vld_d, vld_q;
  logic                       load_d, load_q;
  logic                       ovf_d, ovf_q;
  logic                       add_ovf;

  always_comb begin
    // Operands widened first so the full-precision product is kept
    mul_full     = (2*DATA_W)'(op_a) * (2*DATA_W)'(op_b);
    prod_d       = issue ? ACC_W'(mul_full) : prod_q;
    vld_d        = issue;
    load_d       = load;
    sum          = acc_q + prod_q;
    // Signed overflow: both addends share a sign that the sum does not
    add_ovf      = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
    result       = load_q ? prod_q : sum;
    result_valid = vld_q && !load_q;
    acc_d        = vld_q ? result : acc_q;
    // A new overflow in the same cycle as a clear takes priority
    ovf_d        = (ovf_q && !ovf_clr) || (result_valid && add_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
      vld_q  <= 1'b0;
      load_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
      load_q <= load_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: rtl/matrix_mult_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_mult_sequencer                                         |
// | Purpose  : Avalon-MM slave computing C = A x B for 2x2 signed matrices   |
// |            by sequencing eight products through one shared MAC.          |
// | Ports    : clk, rst             - clock, async active-high reset         |
// |            avs_address[3:0]     - word address                           |
// |            avs_read, avs_write  - bus strobes                            |
// |            avs_writedata[31:0]  - write data                             |
// |            avs_byteenable[3:0]  - byte lanes (only 0/1 used)             |
// |            avs_readdata[31:0]   - read data, one cycle after avs_read    |
// |            irq                  - one-cycle completion pulse             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module matrix_mult_sequencer
  import matrix_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,  // at most 16: operands live in lanes 0/1
  parameter int ACC_W  = ACC_W_DEFAULT    // must be >= 2*DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  state_e                   state_q, state_d;
  logic [2:0]               step_q, step_d;
  logic [1:0]               pend_elem_q, pend_elem_d;
  logic [7:0][DATA_W-1:0]   op_q, op_d;      // bus-visible A (0..3) and B (4..7)
  logic [3:0][DATA_W-1:0]   wa_q, wa_d;      // working snapshot of A
  logic [3:0][DATA_W-1:0]   wb_q, wb_d;      // working snapshot of B
  logic [3:0][ACC_W-1:0]    wc_q, wc_d;      // results of the run in flight
  logic [3:0][ACC_W-1:0]    c_q, c_d;        // committed, bus-visible results
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     irq_q, irq_d;
  logic [31:0]              rdata_q, rdata_d;

  logic                     busy;
  logic                     wr_op, wr_ctrl;
  logic                     start_req, start_acc;
  logic                     clr_err, clr_ovf;
  logic [1:0]               elem;
  logic [1:0]               a_idx, b_idx;
  logic                     mac_issue, mac_load;
  logic signed [DATA_W-1:0] mac_a, mac_b;
  logic signed [ACC_W-1:0]  mac_result;
  logic                     mac_valid;
  logic                     ovf;
  logic [31:0]              rd_word;

  // Upper write lanes carry nothing for this block
  logic unused_bus;
  assign unused_bus = ^{avs_writedata[31:16], avs_byteenable[3:2]};

  // ---------------- bus decode ----------------
  always_comb begin
    busy      = (state_q == ST_MUL) || (state_q == ST_DRAIN);
    wr_op     = avs_write && !avs_address[3];
    wr_ctrl   = avs_write && (avs_address == ADDR_CTRL) && avs_byteenable[0];
    start_req = wr_ctrl && avs_writedata[CTRL_START];
    start_acc = start_req && !busy;
    clr_err   = wr_ctrl && avs_writedata[CTRL_CLR_ERR];
    clr_ovf   = wr_ctrl && avs_writedata[CTRL_CLR_OVF];
  end

  // ---------------- operand registers and error flag ----------------
  always_comb begin
    op_d = op_q;
    if (wr_op && !busy) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (avs_byteenable[b/8]) begin
          op_d[avs_address[2:0]][b] = avs_writedata[b];
        end
      end
    end
    // Rejected writes while busy set err even when a clear arrives together
    err_d = (err_q && !clr_err) || (busy && (wr_op || start_req));
  end

  // ---------------- MAC operand selection ----------------
  // Step k: element e = k>>1 (c11,c12,c21,c22), term t = k&1,
  // product A[e>>1][t] * B[t][e&1].
  always_comb begin
    elem      = step_q[2:1];
    a_idx     = {elem[1], step_q[0]};
    b_idx     = {step_q[0], elem[0]};
    mac_a     = wa_q[a_idx];
    mac_b     = wb_q[b_idx];
    mac_issue = (state_q == ST_MUL);
    mac_load  = !step_q[0];
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk          (clk),
    .rst          (rst),
    .issue        (mac_issue),
    .load         (mac_load),
    .op_a         (mac_a),
    .op_b         (mac_b),
    .ovf_clr      (clr_ovf),
    .result       (mac_result),
    .result_valid (mac_valid),
    .ovf          (ovf)
  );

  // ---------------- sequencer FSM ----------------
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pend_elem_d = pend_elem_q;
    wa_d        = wa_q;
    wb_d        = wb_q;
    wc_d        = wc_q;
    c_d         = c_q;
    done_d      = done_q;
    irq_d       = 1'b0;

    // The MAC result lags its issue by one cycle, so the element index
    // travels alongside it in pend_elem.
    if (mac_valid) begin
      wc_d[pend_elem_q] = mac_result;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_MUL: begin
        pend_elem_d = elem;
        step_d      = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        irq_d   = 1'b1;
      end
      ST_DONE: begin
        c_d     = wc_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // start_acc is only possible from IDLE or DONE
    if (start_acc) begin
      state_d = ST_MUL;
      step_d  = 3'd0;
      wa_d    = op_q[3:0];
      wb_d    = op_q[7:4];
      done_d  = 1'b0;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    rd_word = 32'h0;
    if (!avs_address[3]) begin
      rd_word = 32'($signed(op_q[avs_address[2:0]]));
    end else begin
      case (avs_address)
        ADDR_STATUS: begin
          rd_word[STAT_BUSY] = busy;
          rd_word[STAT_DONE] = done_q;
          rd_word[STAT_ERR]  = err_q;
          rd_word[STAT_OVF]  = ovf;
        end
        ADDR_C11: rd_word = 32'($signed(c_q[0]));
        ADDR_C12: rd_word = 32'($signed(c_q[1]));
        ADDR_C21: rd_word = 32'($signed(c_q[2]));
        ADDR_C22: rd_word = 32'($signed(c_q[3]));
        default:  rd_word = 32'h0;
      endcase
    end
    rdata_d = avs_read ? rd_word : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      pend_elem_q <= '0;
      op_q        <= '0;
      wa_q        <= '0;
      wb_q        <= '0;
      wc_q        <= '0;
      c_q         <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pend_elem_q <= pend_elem_d;
      op_q        <= op_d;
      wa_q        <= wa_d;
      wb_q        <= wb_d;
      wc_q        <= wc_d;
      c_q         <= c_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_matrix_mult_sequencer                                      |
// | Purpose  : Scoreboard bench for matrix_mult_sequencer. The driver pushes |
// |            expected read data / irq cycles; monitors pop and compare.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_matrix_mult_sequencer;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        irq;

  matrix_mult_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_byteenable (avs_byteenable),
    .avs_readdata   (avs_readdata),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       nm_q[$];
  int          irq_q[$];
  logic        rd_d1 = 1'b0;

  always @(posedge clk) rd_d1 <= avs_read;

  always @(negedge clk) begin
    logic [31:0] e;
    string       n;
    if (rd_d1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read cycle %0d got %h required no data", cyc, avs_readdata);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (avs_readdata !== e) begin
          errors++;
          $display("FAIL %s cycle %0d got %h required %h", n, cyc, avs_readdata, e);
        end
      end
    end
    if (irq_q.size() > 0 && irq_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL irq_missing expected at cycle %0d got none", irq_q[0]);
      void'(irq_q.pop_front());
    end
    if (irq !== 1'b0) begin
      checks++;
      if (irq_q.size() > 0 && irq_q[0] == cyc) begin
        void'(irq_q.pop_front());
      end else begin
        errors++;
        $display("FAIL irq_pulse cycle %0d got %b required 0", cyc, irq);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] m_op [8];
  logic [31:0] m_c  [4];
  logic        m_busy, m_done, m_err, m_ovf;
  logic [31:0] n_c  [4];
  bit          n_ov [4];

  // C = A x B with plain integer arithmetic; overflow = two-term sum
  // leaving the signed 32-bit range.
  function automatic void compute_next();
    longint p0, p1, s;
    int     i, j;
    for (int e = 0; e < 4; e++) begin
      i  = e / 2;
      j  = e % 2;
      p0 = longint'($signed(m_op[i*2]))     * longint'($signed(m_op[4+j]));
      p1 = longint'($signed(m_op[i*2 + 1])) * longint'($signed(m_op[6+j]));
      s  = p0 + p1;
      n_c[e]  = s[31:0];
      n_ov[e] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    if (a < 4'd8) return {{16{m_op[a][15]}}, m_op[a]};
    case (a)
      ADDR_STATUS: return {28'd0, m_ovf, m_err, m_done, m_busy};
      ADDR_C11:    return m_c[0];
      ADDR_C12:    return m_c[1];
      ADDR_C21:    return m_c[2];
      ADDR_C22:    return m_c[3];
      default:     return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    if (a < 4'd8) begin
      if (m_busy) m_err = 1'b1;
      else begin
        if (be[0]) m_op[a][7:0]  = d[7:0];
        if (be[1]) m_op[a][15:8] = d[15:8];
      end
    end else if (a == ADDR_CTRL && be[0]) begin
      if (d[1]) m_err = 1'b0;
      if (d[2]) m_ovf = 1'b0;
      if (d[0] && m_busy) m_err = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) m_op[k] = '0;
    for (int k = 0; k < 4; k++) m_c[k] = '0;
    m_busy = 0; m_done = 0; m_err = 0; m_ovf = 0;
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    avs_address = '0; avs_read = 0; avs_write = 0;
    avs_writedata = '0; avs_byteenable = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_write = 1; avs_writedata = d; avs_byteenable = be;
    tick();
    bus_idle();
    model_write(a, d, be);
  endtask

  task automatic rd(input logic [3:0] a, input string nm);
    exp_q.push_back(model_read(a));
    nm_q.push_back(nm);
    avs_address = a; avs_read = 1;
    tick();
    bus_idle();
  endtask

  task automatic rd_lit(input logic [3:0] a, input logic [31:0] v, input string nm);
    exp_q.push_back(v);
    nm_q.push_back(nm);
    avs_address = a; avs_read = 1;
    tick();
    bus_idle();
  endtask

  task automatic load_ops(input logic [15:0] a11, a12, a21, a22, b11, b12, b21, b22);
    logic [15:0] v [8];
    logic [31:0] d;
    v = '{a11, a12, a21, a22, b11, b12, b21, b22};
    for (int k = 0; k < 8; k++) begin
      d = $urandom();          // upper lanes are junk the DUT must ignore
      d[15:0] = v[k];
      wr(4'(k), d, 4'hF);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    irq_q.delete();
    tick();
  endtask

  // mode 0: normal run with STATUS polled each cycle
  // mode 1: start at T+3 and a11 write at T+4 while busy, C11 read at T+5
  // mode 2: reset asserted at T+5
  task automatic run(input int mode, input logic [31:0] sd);
    compute_next();
    avs_address = ADDR_CTRL; avs_write = 1; avs_writedata = sd; avs_byteenable = 4'h1;
    irq_q.push_back(cyc + 10);
    tick();
    bus_idle();
    if (sd[1]) m_err = 0;
    if (sd[2]) m_ovf = 0;
    m_busy = 1;
    m_done = 0;
    for (int k = 1; k <= 10; k++) begin
      // element e finishes its add in T+3+2e; ovf is visible one cycle later
      for (int e = 0; e < 4; e++) if (n_ov[e] && k == 4 + 2*e) m_ovf = 1;
      if (k == 10) begin m_busy = 0; m_done = 1; end
      if (mode == 1 && k == 3)      wr(ADDR_CTRL, 32'h1, 4'h1);
      else if (mode == 1 && k == 4) wr(ADDR_A11, 32'h9, 4'h3);
      else if (mode == 1 && k == 5) rd(ADDR_C11, "busy_c11_prior");
      else if (mode == 2 && k == 4) tick();
      else if (mode == 2 && k == 5) begin do_reset(); return; end
      else rd(ADDR_STATUS, "run_status");
    end
    for (int e = 0; e < 4; e++) m_c[e] = n_c[e];
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < 16; a++) rd(4'(a), nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv [8];
    logic [31:0] r;
    rst = 1;
    bus_idle();
    model_reset();
    repeat (3) tick();
    rst = 0;
    tick();

    // reset state
    read_all("reset_state");

    // basic multiply
    load_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    run(0, 32'h1);
    rd_lit(ADDR_C11, 32'd19, "basic_c11");
    rd_lit(ADDR_C12, 32'd22, "basic_c12");
    rd_lit(ADDR_C21, 32'd43, "basic_c21");
    rd_lit(ADDR_C22, 32'd50, "basic_c22");
    rd_lit(ADDR_STATUS, 32'h2, "basic_status");

    // negative operands
    load_ops(16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF);
    run(0, 32'h1);
    rd_lit(ADDR_C11, 32'd1, "neg_c11");
    rd_lit(ADDR_C12, 32'd0, "neg_c12");
    rd_lit(ADDR_C21, 32'd0, "neg_c21");
    rd_lit(ADDR_C22, 32'd1, "neg_c22");
    rd_lit(ADDR_A11, 32'hFFFF_FFFF, "neg_a11_sext");

    // overflow
    load_ops(16'h8000, 16'h8000, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h8000, 16'h0);
    run(0, 32'h1);
    rd_lit(ADDR_C11, 32'h8000_0000, "ovf_c11");
    rd_lit(ADDR_STATUS, 32'hA, "ovf_status_set");
    wr(ADDR_CTRL, 32'h4, 4'h1);
    rd_lit(ADDR_STATUS, 32'h2, "ovf_status_cleared");

    // busy protection
    load_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    run(0, 32'h1);
    load_ops(16'd2, 16'd1, 16'd0, 16'd3, 16'd1, 16'd1, 16'd4, 16'd5);
    run(1, 32'h1);
    for (int a = 10; a < 14; a++) rd(4'(a), "busy_result");
    rd_lit(ADDR_C11, 32'd6, "busy_c11_new");
    rd_lit(ADDR_STATUS, 32'h6, "busy_err_set");
    rd_lit(ADDR_A11, 32'd2, "busy_a11_kept");
    run(0, 32'h3);          // start with clear-err in the same write
    rd_lit(ADDR_STATUS, 32'h2, "start_clears_err");

    // byte enables and ignored writes
    wr(ADDR_A11, 32'h0000_1234, 4'h1);
    wr(ADDR_A11, 32'h0000_AB00, 4'h2);
    rd_lit(ADDR_A11, 32'hFFFF_AB34, "be_a11");
    wr(ADDR_CTRL, 32'h1, 4'h2);
    rd(ADDR_STATUS, "ctrl_no_be0_no_start");
    repeat (12) tick();
    wr(4'd14, 32'hFFFF_FFFF, 4'hF);
    rd_lit(4'd14, 32'h0, "unmapped_read");
    rd_lit(ADDR_CTRL, 32'h0, "ctrl_read_zero");

    // reset mid-operation, then a fresh run
    load_ops(16'd7, 16'd3, 16'hFFF0, 16'd9, 16'd2, 16'd11, 16'd5, 16'hFF00);
    run(2, 32'h1);
    read_all("midreset_zero");
    load_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    run(0, 32'h1);
    rd_lit(ADDR_C11, 32'd19, "fresh_c11");
    rd_lit(ADDR_C22, 32'd50, "fresh_c22");

    // randomized runs
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 5))
          0:       rv[k] = 16'h8000;
          1:       rv[k] = 16'h7FFF;
          default: rv[k] = 16'($urandom());
        endcase
      end
      load_ops(rv[0], rv[1], rv[2], rv[3], rv[4], rv[5], rv[6], rv[7]);
      r = 32'h1 | (32'($urandom_range(0, 3)) << 1);
      run(0, r);
      for (int a = 10; a < 14; a++) rd(4'(a), "rand_c");
      rd(ADDR_STATUS, "rand_status");
      rd(4'($urandom_range(0, 7)), "rand_op");
    end

    repeat (4) tick();
    checks++;
    if (irq_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got irq %0d reads %0d pending required 0",
               irq_q.size(), exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_mult_sequencer.md
Name: matrix_mult_sequencer

Overview:
- Avalon-MM slave controller for the 2x2 matrix multiply C = A x B, with signed 16-bit operands and 32-bit results.
- Holds the operand and result register file and accepts a start command.
- Sequences the 8 products through one shared registered multiplier instead of 8 parallel multipliers.
- Commits all four results atomically, then raises done and a one-cycle irq.

Parameters:
- DATA_W, 16, operand width (signed two's complement).
- ACC_W, 32, product/result width; must be >= 2*DATA_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- avs_address  in  4  word address (map below).
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  byte lane enables.
- avs_readdata  out  32  read data, readLatency = 1.
- irq  out  1  one-cycle pulse on completion.

Behaviour:
- Register map:
  - 0..3 = a11,a12,a21,a22; 4..7 = b11,b12,b21,b22. R/W, low DATA_W bits; lanes 0/1 honoured per byte; lanes 2/3 ignored.
  - 8 = CTRL, write-only, requires byteenable[0]. bit0 start; bit1 clear err; bit2 clear ovf.
  - 9 = STATUS, RO. bit0 busy, bit1 done, bit2 err, bit3 ovf.
  - 10..13 = c11,c12,c21,c22, RO.
  - 14..15 unmapped: read 0, writes ignored.
- Read data:
  - Registered: read issued in cycle T returns data in T+1.
  - Operands read back sign-extended to 32 bits.
- Reset values: all registers 0, avs_readdata 0, irq 0, state IDLE.
- FSM states: IDLE, MUL, DRAIN, DONE.
  - IDLE: a start write at cycle T snapshots A/B into working regs at the end of T; step counter cleared; next state MUL.
  - MUL, cycles T+1..T+8: step k = 0..7 issues product A[i][t]*B[t][j], where element e = k>>1 (order c11,c12,c21,c22), i = e>>1, j = e&1, t = k&1.
  - Multiplier has 1-cycle registered latency.
  - Accumulator: loads the product on t=0 and adds it on t=1. The finished element is written to its working C slot.
  - DRAIN, cycle T+9: final accumulate.
  - DONE, cycle T+10: commit all four working C values to the visible C regs together; done=1; busy=0; irq=1 for this cycle only; return to IDLE.
- busy = 1 in MUL/DRAIN/DONE-entry, i.e. cycles T+1..T+9. done clears when a start is accepted.
- Reads of C while busy return the previous committed results.
- Writes to operands or start while busy:
  - Ignored; err set (sticky).
  - A start write with bit1 set still clears err.
  - Clear and set in the same cycle: set wins.
- Arithmetic:
  - Products are signed DATA_W x DATA_W, sign-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W.
  - ovf (sticky) is set when a signed add overflows; cleared only by CTRL bit2 or reset.
- Simultaneous start and clear bits in one write: both take effect.
- Reset asserted mid-operation: immediate return to all-zero state. No irq; previous results are lost.

Decomposition:
- matrix_pkg holds:
  - Address constants (ADDR_A11..ADDR_C22, ADDR_CTRL, ADDR_STATUS).
  - CTRL/STATUS bit index constants.
  - FSM state enum.
  - DATA_W/ACC_W defaults.
- Sub-module mac_unit: registered signed multiplier plus accumulator with load/add control and an overflow flag. The sequencer owns the FSM, step counter, register file and bus logic.

Test Plan:
- Basic multiply:
  - Stimulus: A=[[1,2],[3,4]], B=[[5,6],[7,8]], start at T.
  - Required: busy in T+1..T+9; irq pulse and done at T+10.
  - Required: C=[[19,22],[43,50]], ovf=0.
- Negative operands:
  - Stimulus: A=B=[[-1,0],[0,-1]].
  - Required: C=[[1,0],[0,1]]; reads of a11 return 0xFFFFFFFF.
- Overflow:
  - Stimulus: a11=a12=b11=b21=0x8000, other operands 0.
  - Required: c11=0x80000000, ovf=1.
  - Required: CTRL write 0x4 clears ovf.
- Busy protection:
  - Stimulus: second start at T+3 and write a11=9 at T+4.
  - Required: both ignored, err=1, results unchanged from the first run.
  - Required: C reads at T+5 return the prior results.
- Reset mid-op:
  - Stimulus: assert rst at T+5.
  - Required: all registers read 0 and irq never pulses.
  - Required: a fresh run afterwards completes normally.
- Byte enables:
  - Stimulus: write 0x1234 to a11 with byteenable=0x1, then 0xAB00 with byteenable=0x2.
  - Required: a11 reads 0xFFFFAB34.
  - Required: a CTRL write with byteenable[0]=0 does not start.
